// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared FSM state encodings and default timing constants for
//                the push-button debouncer (defaults assume a 100 MHz clk_in).
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Debouncer FSM state encodings
    localparam logic [1:0] c_IDLE_LOW  = 2'd0;
    localparam logic [1:0] c_WAIT_HIGH = 2'd1;
    localparam logic [1:0] c_HELD_HIGH = 2'd2;
    localparam logic [1:0] c_WAIT_LOW  = 2'd3;

    // Default timing for a 100 MHz clock: 10 ms settle, 1 s long press
    localparam int c_STABLE_CYCLES_DEF = 1_000_000;
    localparam int c_LONG_CYCLES_DEF   = 100_000_000;
    localparam int c_CNT_W_DEF         = 27;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchronizer with synchronous active-high
//                reset. Output is the input delayed by two clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Debounces a raw push-button. Produces a clean level, one-cycle
//                press/release strobes and a wrapping 8-bit press counter.
//                Optional long-press strobe enabled by macro LONGPRESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = c_STABLE_CYCLES_DEF,
    parameter int LONG_CYCLES   = c_LONG_CYCLES_DEF,
    parameter int CNT_W         = c_CNT_W_DEF
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count,
    output logic       long_press
);

    localparam logic [CNT_W-1:0] c_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Reject configurations where the timers cannot reach their terminal counts
    generate
        if ((STABLE_CYCLES < 2) || ((64'd1 << CNT_W) <= 64'(LONG_CYCLES))
            || ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES))) begin : g_bad_cfg
            $error("button_debounce: invalid STABLE_CYCLES/LONG_CYCLES/CNT_W");
        end
    endgenerate

    logic             w_btn_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [7:0]       r_count;

    sync_2ff u_sync (
        .clk (clk_in),
        .rst (rst),
        .i_d (btn_in),
        .o_q (w_btn_sync)
    );

    // Debounce FSM: a new level must hold STABLE_CYCLES synchronized cycles
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= c_IDLE_LOW;
            r_timer   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                c_IDLE_LOW: begin
                    r_level <= 1'b0;
                    if (w_btn_sync) begin
                        r_state <= c_WAIT_HIGH;
                        r_timer <= CNT_W'(1);
                    end
                end
                c_WAIT_HIGH: begin
                    if (!w_btn_sync) begin
                        r_state <= c_IDLE_LOW;
                        r_timer <= '0;
                    end else if (r_timer == c_STABLE_LAST) begin
                        r_state <= c_HELD_HIGH;
                        r_timer <= '0;
                        r_press <= 1'b1;
                        r_level <= 1'b1;
                        r_count <= r_count + 8'd1;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                c_HELD_HIGH: begin
                    r_level <= 1'b1;
                    if (!w_btn_sync) begin
                        r_state <= c_WAIT_LOW;
                        r_timer <= CNT_W'(1);
                    end
                end
                c_WAIT_LOW: begin
                    if (w_btn_sync) begin
                        // Bounce during release: stay pressed, no strobe
                        r_state <= c_HELD_HIGH;
                        r_timer <= '0;
                    end else if (r_timer == c_STABLE_LAST) begin
                        r_state   <= c_IDLE_LOW;
                        r_timer   <= '0;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE_LOW;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign press_count   = r_count;

`ifdef LONGPRESS_EN
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_LONG_SAT  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] r_long_cnt;
    logic             r_long;

    // Hold-time counter; saturates past the terminal count so each press strobes once
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (r_state == c_HELD_HIGH) begin
                if (r_long_cnt == c_LONG_LAST) begin
                    r_long <= 1'b1;
                end
                if (!w_btn_sync) begin
                    r_long_cnt <= '0;
                end else if (r_long_cnt != c_LONG_SAT) begin
                    r_long_cnt <= r_long_cnt + CNT_W'(1);
                end
            end else begin
                r_long_cnt <= '0;
            end
        end
    end

    assign long_press = r_long;
`else
    assign long_press = 1'b0;
`endif

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Scoreboard bench for button_debounce (STABLE_CYCLES=8,
//                LONG_CYCLES=40). Long-press expectations follow LONGPRESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int STABLE = 8;
    localparam int LONG   = 40;
    localparam int LAT    = STABLE + 2;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       btn_in = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;
    logic       long_press;

    button_debounce #(
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG),
        .CNT_W         (27)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count),
        .long_press    (long_press)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cycle;
        logic [7:0] count;
        logic       level;
    } ev_t;

    ev_t        q[$];
    int         checks    = 0;
    int         errors    = 0;
    int         n_press   = 0;
    int         n_release = 0;
    logic [7:0] exp_count = 8'd0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(int k, int c, logic [7:0] cnt, logic lvl);
        ev_t e;
        e.kind  = k;
        e.cycle = c;
        e.count = cnt;
        e.level = lvl;
        q.push_back(e);
    endtask

    task automatic handle(int k);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse kind=%0d cycle=%0d required=none", k, cyc);
        end else begin
            e = q.pop_front();
            check("pulse_kind", k, e.kind);
            check("pulse_cycle", cyc, e.cycle);
            check("pulse_level", {31'd0, btn_level}, {31'd0, e.level});
            if (k != K_LONG) check("pulse_count", {24'd0, press_count}, {24'd0, e.count});
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    always @(negedge clk_in) begin
        if (!rst) begin
            if (press_pulse && release_pulse) begin
                checks++;
                errors++;
                $display("FAIL both_pulses actual=1 required=0 (cycle %0d)", cyc);
            end
            if (press_pulse)   begin n_press++;   handle(K_PRESS);   end
            if (long_press)    handle(K_LONG);
            if (release_pulse) begin n_release++; handle(K_RELEASE); end
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Clean press held `hold` cycles, then low for `gap` cycles
    task automatic press_release(int hold, int gap);
        int k;
        k = cyc;
        btn_in = 1'b1;
        exp_count = exp_count + 8'd1;
        push_ev(K_PRESS, k + LAT, exp_count, 1'b1);
`ifdef LONGPRESS_EN
        if (hold > LAT + LONG) push_ev(K_LONG, k + LAT + LONG, exp_count, 1'b1);
`endif
        push_ev(K_RELEASE, k + hold + LAT, exp_count, 1'b0);
        wait_cycles(hold);
        btn_in = 1'b0;
        wait_cycles(gap);
    endtask

    initial begin
        int k;
        int p0;
        int r0;
        logic [7:0] cnt_before;

        // Reset held 3 cycles with the button pressed
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            check("rst_level",   {31'd0, btn_level},     32'd0);
            check("rst_press",   {31'd0, press_pulse},   32'd0);
            check("rst_release", {31'd0, release_pulse}, 32'd0);
            check("rst_count",   {24'd0, press_count},   32'd0);
            check("rst_long",    {31'd0, long_press},    32'd0);
        end
        rst = 1'b0;
        k = cyc;
        exp_count = 8'd1;
        push_ev(K_PRESS, k + LAT, 8'd1, 1'b1);
        wait_cycles(20);
        btn_in = 1'b0;
        push_ev(K_RELEASE, cyc + LAT, 8'd1, 1'b0);
        wait_cycles(30);

        // Clean press held 100 cycles with level checks around both edges
        k = cyc;
        btn_in = 1'b1;
        exp_count = exp_count + 8'd1;
        push_ev(K_PRESS, k + LAT, exp_count, 1'b1);
`ifdef LONGPRESS_EN
        push_ev(K_LONG, k + LAT + LONG, exp_count, 1'b1);
`endif
        push_ev(K_RELEASE, k + 100 + LAT, exp_count, 1'b0);
        wait_cycles(LAT - 1);
        check("level_before_press", {31'd0, btn_level}, 32'd0);
        wait_cycles(1);
        check("level_at_press", {31'd0, btn_level}, 32'd1);
        wait_cycles(100 - LAT);
        btn_in = 1'b0;
        wait_cycles(LAT - 1);
        check("level_before_release", {31'd0, btn_level}, 32'd1);
        wait_cycles(1);
        check("level_at_release", {31'd0, btn_level}, 32'd0);
        wait_cycles(30);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold high
        for (int i = 0; i < 10; i++) begin
            btn_in = (i % 2 == 0);
            wait_cycles(3);
        end
        btn_in = 1'b1;
        exp_count = exp_count + 8'd1;
        push_ev(K_PRESS, cyc + LAT, exp_count, 1'b1);
        wait_cycles(20);
        btn_in = 1'b0;
        push_ev(K_RELEASE, cyc + LAT, exp_count, 1'b0);
        wait_cycles(30);

        // Glitch: 7-cycle high pulse must be ignored
        cnt_before = exp_count;
        btn_in = 1'b1;
        wait_cycles(7);
        btn_in = 1'b0;
        wait_cycles(5);
        check("glitch_level", {31'd0, btn_level}, 32'd0);
        wait_cycles(15);
        check("glitch_count", {24'd0, press_count}, {24'd0, cnt_before});
        check("glitch_level_end", {31'd0, btn_level}, 32'd0);

        // Wrap: clear counter, then 256 presses bring it back to 0
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        exp_count = 8'd0;
        check("count_after_reset", {24'd0, press_count}, 32'd0);
        p0 = n_press;
        r0 = n_release;
        for (int i = 0; i < 256; i++) press_release(12, 12);
        wait_cycles(10);
        check("wrap_count", {24'd0, press_count}, 32'd0);
        check("wrap_presses", n_press - p0, 256);
        check("wrap_releases", n_release - r0, 256);

        wait_cycles(30);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound so the run always terminates
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_button_debounce
`default_nettype wire

// File: doc/button_debounce.md
Name: button_debounce

Overview:
Input-side counterpart to the board's slow LED drivers. Samples a raw, bouncing push-button on clk_in and produces a clean debounced level, single-cycle press/release pulses and a wrapping press counter. Sits between the board pin and user logic such as mode selects and blink-rate changes. Counter-based timing runs on clk_in; no derived clocks.

Parameters:
STABLE_CYCLES, 1_000_000, consecutive synchronized cycles the new level must hold before it is accepted (10 ms at 100 MHz); must be >= 2.
LONG_CYCLES, 100_000_000, held-high cycles before a long-press pulse (1 s at 100 MHz); used only with LONGPRESS_EN.
CNT_W, 27, timer width; must satisfy 2**CNT_W > max(STABLE_CYCLES, LONG_CYCLES).

Ports:
clk_in  input  1  system clock, all logic on its rising edge
rst  input  1  synchronous, active-high reset
btn_in  input  1  raw button pin, asynchronous, active-high, bouncing
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle strobe on each accepted press
release_pulse  output  1  one-cycle strobe on each accepted release
press_count  output  8  number of accepted presses, modulo 256
long_press  output  1  one-cycle strobe when a press is held LONG_CYCLES (see Optional Feature)

Behaviour:
- Reset: one clock; reset is synchronous and active-high on clk_in/rst. While rst is high at a clk_in edge, all of the following clear to 0: both synchronizer flops, timer, state (IDLE_LOW), btn_level, press_pulse, release_pulse, press_count and long_press.
- Synchronizer: two-flop chain; btn_sync = btn_in delayed by 2 cycles. Only btn_sync is used downstream.
- FSM states: IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW.
- IDLE_LOW: btn_level=0. If btn_sync=1 -> WAIT_HIGH with timer=1.
- WAIT_HIGH: if btn_sync=0 -> IDLE_LOW with timer=0 and no pulse. Else if timer==STABLE_CYCLES-1 -> HELD_HIGH with timer=0; in the same cycle register press_pulse=1, btn_level=1 and press_count+1. Else timer+1.
- HELD_HIGH: btn_level=1. If btn_sync=0 -> WAIT_LOW with timer=1.
- WAIT_LOW: if btn_sync=1 -> HELD_HIGH, no pulse. Else if timer==STABLE_CYCLES-1 -> IDLE_LOW; register release_pulse=1 and btn_level=0. Else timer+1.
- Latency: the first clean rising edge of btn_in sampled at cycle N gives press_pulse and btn_level=1 at cycle N+2+STABLE_CYCLES. Release latency is the same.
- Pulses are registered, high for exactly one cycle, and never both high in the same cycle.
- press_count wraps from 255 to 0 with no flag.
- Glitches shorter than STABLE_CYCLES synchronized cycles cause no output change.
- Reset mid-operation: state returns to IDLE_LOW. If the button is still held after reset, it is accepted as a new press after the full latency.

Optional Feature:
Macro LONGPRESS_EN.
- Defined: in HELD_HIGH a separate counter increments every cycle. When it reaches LONG_CYCLES-1, long_press pulses for one cycle. The counter then saturates, so there is one pulse per press. The counter clears on entry to WAIT_LOW and on reset.
- Undefined: long_press is tied to 0 and no long-press counter is synthesized.

Decomposition:
- Shared package debounce_pkg holds the state encodings (2-bit: IDLE_LOW=0, WAIT_HIGH=1, HELD_HIGH=2, WAIT_LOW=3) and the default timing constants for a 100 MHz clk_in.
- One sub-module, sync_2ff (1-bit, two-flop synchronizer with synchronous reset), is instantiated once; the rest stays in button_debounce.

Test Plan:
All scenarios use STABLE_CYCLES=8 and LONG_CYCLES=40.
- Reset: hold rst for 3 cycles with btn_in=1 -> all outputs 0 during reset; press_pulse fires 10 cycles after rst falls; press_count=1.
- Clean press at cycle 100, release at cycle 200 -> press_pulse at cycle 110 only, btn_level high over cycles 110-209, release_pulse at cycle 210.
- Bounce: toggle btn_in every 3 cycles for 30 cycles, then hold 1 -> exactly one press_pulse, 10 cycles after the final rising edge; press_count +1.
- Glitch: 7-cycle high pulse on btn_in, otherwise low -> no pulse, btn_level stays 0, press_count unchanged.
- Wrap: 256 clean presses -> press_count returns to 0; 256 press_pulse and 256 release_pulse observed.
- LONGPRESS_EN defined, hold btn_in for 100 cycles -> long_press high for exactly one cycle, 40 cycles after press_pulse. Macro undefined -> long_press stays 0.
